ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Round-robin arbiter sharing one single-port memory device port (ram_2p port A style: req/we/be/addr/wdata in, in-order rvalid/rdata out) between NrHosts OBI-style data hosts, e.g. core data port plus a DMA engine.
- Grants at most one request per cycle.
- Records the granted host ID in an in-order tracking FIFO.
- Routes each device response back to the host that issued it.
- Sits between the bus device slot for Ram and u_ram.

Parameters:
NrHosts, 2, number of requesting hosts (>=2).
DataWidth, 32, data bus width.
AddressWidth, 32, address bus width.
MaxOutstanding, 2, tracking FIFO depth; power of two, >=1.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
host_req_i  in  [NrHosts] x 1  host request; held with attributes until granted
host_gnt_o  out  [NrHosts] x 1  grant, same cycle as selection
host_addr_i  in  [NrHosts] x AddressWidth  request address
host_we_i  in  [NrHosts] x 1  write enable
host_be_i  in  [NrHosts] x DataWidth/8  byte enables
host_wdata_i  in  [NrHosts] x DataWidth  write data
host_rvalid_o  out  [NrHosts] x 1  response valid, routed per host
host_rdata_o  out  [NrHosts] x DataWidth  response data; driven to all hosts, qualified by rvalid
host_err_o  out  [NrHosts] x 1  response error, routed with rvalid
device_req_o  out  1  device request; device accepts every cycle (no gnt)
device_addr_o  out  AddressWidth  muxed address
device_we_o  out  1  muxed write enable
device_be_o  out  DataWidth/8  muxed byte enables
device_wdata_o  out  DataWidth  muxed write data
device_rvalid_i  in  1  device response valid, in order, latency >=1, also for writes
device_rdata_i  in  DataWidth  device read data
device_err_i  in  1  device error
outstanding_o  out  $clog2(MaxOutstanding+1)  in-flight request count
orphan_rsp_o  out  1  one-cycle pulse: device_rvalid_i seen with FIFO empty

Behaviour:
- Reset state (rst_i high at posedge):
  - Priority pointer = 0; FIFO empty; outstanding_o = 0; orphan_rsp_o = 0.
  - Outputs while rst_i is high: all host_gnt_o, host_rvalid_o, host_err_o, device_req_o = 0; muxed device attributes = 0.
- Grant enable: can_issue = (count < MaxOutstanding) || device_rvalid_i. Pop-on-response bypasses the full condition.
- Arbitration (combinational):
  - Among requesting hosts, pick the first at or after the pointer, modulo NrHosts.
  - If can_issue and any request: exactly one host_gnt_o high; device_req_o = 1; device attributes = that host's inputs, same cycle.
  - Otherwise no grant, device_req_o = 0, device attributes = 0.
- Pointer update: on a grant to host k, pointer <= (k+1) mod NrHosts next cycle. Unchanged when there is no grant.
- Tracking FIFO push: on grant, push k at the write pointer.
- Tracking FIFO pop: on device_rvalid_i with FIFO non-empty, pop the head ID h.
  - host_rvalid_o[h] = 1 and host_err_o[h] = device_err_i, same cycle (combinational from FIFO head).
  - All other hosts' rvalid/err = 0.
- Push and pop in the same cycle: count unchanged; both pointers advance. Pointers wrap at MaxOutstanding.
- device_rvalid_i with FIFO empty:
  - No host_rvalid_o asserted.
  - orphan_rsp_o = 1 for that cycle (combinational).
- Reset mid-operation:
  - FIFO contents discarded.
  - Responses arriving after reset for pre-reset requests are treated as orphans and flagged.
- A request not granted stays pending; the host must hold it. The block adds no request or response latency beyond the device's own.
- Width rule: count is $clog2(MaxOutstanding+1) bits; it must never exceed MaxOutstanding. Assertion required.

Decomposition:
- Package ram_arbiter_pkg:
  - function for the next round-robin index;
  - localparam-style helpers for the host-ID width ($clog2(NrHosts), min 1).
- One sub-module: ram_arbiter_id_fifo.
  - Synchronous active-high reset, depth MaxOutstanding, ID width parameter.
  - Ports: push, pop, wdata, rdata head, empty, full, count; supports simultaneous push/pop when full.

Test Plan:
- Fairness: NrHosts=2, MaxOutstanding=2, both hosts request continuously, device latency 1 -> grants alternate 0,1,0,1 for 8 cycles; each host sees 4 rvalids, in issue order, with correct rdata.
- Full stall: latency 3, MaxOutstanding=2, host 0 continuous requests -> grants in cycles 0,1; no grant in cycle 2; in cycle 3 rvalid arrives and grant reissues same cycle; outstanding_o never exceeds 2.
- Routing: host 1 reads addr 0x200010 (data 0xDEADBEEF), then host 0 writes; latency 2 -> host_rvalid_o[1] with rdata 0xDEADBEEF, then host_rvalid_o[0]; no cross-delivery.
- Error routing: device_err_i=1 on the response to host 1's request -> host_err_o[1]=1 in that rvalid cycle only; host_err_o[0] stays 0.
- Orphan: device_rvalid_i=1 with FIFO empty -> orphan_rsp_o high exactly 1 cycle, all host_rvalid_o 0, outstanding_o stays 0.
- Reset mid-flight: 2 outstanding, rst_i high 1 cycle, then 2 late rvalids -> outstanding_o=0 after reset, two orphan pulses, pointer restarts at host 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_pkg
// Purpose  : Shared helpers for the RAM arbiter: host-ID / pointer / counter
//            width functions and the round-robin successor function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

   // Width of a host index; a single bit is kept even for degenerate counts.
   function automatic int unsigned id_width(input int unsigned n_hosts);
      return (n_hosts <= 2) ? 1 : $clog2(n_hosts);
   endfunction

   // Width of a read/write pointer into a FIFO of the given depth.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Width of an occupancy counter that must be able to hold 'depth'.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Next host index after idx, wrapping at n_hosts.
   function automatic int unsigned rr_next(input int unsigned idx,
                                           input int unsigned n_hosts);
      return (idx + 1 >= n_hosts) ? 0 : idx + 1;
   endfunction

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_arbiter_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_id_fifo
// Purpose  : In-order FIFO of granted host IDs. The head tells the arbiter
//            which host owns the next device response.
// Ports    : clk_i, rst_i      clock, synchronous active-high reset
//            push_i, wdata_i   enqueue an ID
//            pop_i, rdata_o    dequeue; rdata_o is the current head
//            empty_o, full_o   occupancy flags
//            count_o           number of stored IDs (0..Depth)
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter_id_fifo
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned Depth   = 2,
   parameter int unsigned IdWidth = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [IdWidth-1:0]         wdata_i,
   output logic [IdWidth-1:0]         rdata_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(Depth+1)-1:0] count_o
);

   localparam int unsigned PtrW = ptr_width(Depth);
   localparam int unsigned CntW = cnt_width(Depth);
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
   localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

   logic [IdWidth-1:0] mem_q [Depth];
   logic [PtrW-1:0]    wptr_q, wptr_d;
   logic [PtrW-1:0]    rptr_q, rptr_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DepthCnt);
   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

   // A push into a full FIFO is legal only when the head leaves this cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrOne;
      if (do_pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrOne;
      if (do_push && !do_pop)      count_d = count_q + CntOne;
      else if (!do_push && do_pop) count_d = count_q - CntOne;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (do_push) mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule : ram_arbiter_id_fifo
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin arbiter sharing one single-port RAM port between
//            NrHosts OBI-style data hosts. At most one grant per cycle; the
//            granted host ID is tracked in order so every device response is
//            routed back to its issuer.
// Ports    : clk_i, rst_i            clock, synchronous active-high reset
//            host_*_i / host_*_o     per-host request / grant / response
//            device_*_o / device_*_i muxed RAM request, in-order response
//            outstanding_o           in-flight request count
//            orphan_rsp_o            response seen with nothing in flight
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned NrHosts        = 2,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddressWidth   = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic [NrHosts-1:0]                       host_req_i,
   output logic [NrHosts-1:0]                       host_gnt_o,
   input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
   input  logic [NrHosts-1:0]                       host_we_i,
   input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
   input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
   output logic [NrHosts-1:0]                       host_rvalid_o,
   output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
   output logic [NrHosts-1:0]                       host_err_o,
   output logic                                     device_req_o,
   output logic [AddressWidth-1:0]                  device_addr_o,
   output logic                                     device_we_o,
   output logic [DataWidth/8-1:0]                   device_be_o,
   output logic [DataWidth-1:0]                     device_wdata_o,
   input  logic                                     device_rvalid_i,
   input  logic [DataWidth-1:0]                     device_rdata_i,
   input  logic                                     device_err_i,
   output logic [$clog2(MaxOutstanding+1)-1:0]      outstanding_o,
   output logic                                     orphan_rsp_o
);

   localparam int unsigned IdW  = id_width(NrHosts);
   localparam int unsigned CntW = cnt_width(MaxOutstanding);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   logic [IdW-1:0]  ptr_q, ptr_d;
   logic [IdW-1:0]  sel_idx;
   logic [IdW-1:0]  head_id;
   logic            any_req, can_issue, grant;
   logic            fifo_empty, fifo_full, fifo_pop;
   logic [CntW-1:0] count;

   // Scan hosts starting at the priority pointer; first requester wins.
   always_comb begin
      logic [IdW-1:0] cand;
      sel_idx = '0;
      any_req = 1'b0;
      cand    = ptr_q;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         if (!any_req && host_req_i[cand]) begin
            sel_idx = cand;
            any_req = 1'b1;
         end
         cand = IdW'(rr_next(32'(cand), NrHosts));
      end
   end

   // A response this cycle frees a FIFO slot, so a full FIFO may still issue.
   assign can_issue = !fifo_full || device_rvalid_i;
   assign grant     = any_req && can_issue && !rst_i;
   assign ptr_d     = grant ? IdW'(rr_next(32'(sel_idx), NrHosts)) : ptr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   always_comb begin
      host_gnt_o     = '0;
      device_req_o   = grant;
      device_addr_o  = '0;
      device_we_o    = 1'b0;
      device_be_o    = '0;
      device_wdata_o = '0;
      if (grant) begin
         host_gnt_o[sel_idx] = 1'b1;
         device_addr_o       = host_addr_i[sel_idx];
         device_we_o         = host_we_i[sel_idx];
         device_be_o         = host_be_i[sel_idx];
         device_wdata_o      = host_wdata_i[sel_idx];
      end
   end

   assign fifo_pop = device_rvalid_i && !fifo_empty && !rst_i;

   ram_arbiter_id_fifo #(
      .Depth   (MaxOutstanding),
      .IdWidth (IdW)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (grant),
      .pop_i   (fifo_pop),
      .wdata_i (sel_idx),
      .rdata_o (head_id),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (count)
   );

   // Responses go only to the host at the FIFO head.
   always_comb begin
      host_rvalid_o = '0;
      host_err_o    = '0;
      if (fifo_pop) begin
         host_rvalid_o[head_id] = 1'b1;
         host_err_o[head_id]    = device_err_i;
      end
   end

   for (genvar h = 0; h < NrHosts; h++) begin : g_rdata
      assign host_rdata_o[h] = device_rdata_i;
   end

   // Includes late responses to requests discarded by a reset.
   assign orphan_rsp_o  = device_rvalid_i && fifo_empty && !rst_i;
   assign outstanding_o = count;

`ifndef SYNTHESIS
   a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
                                    count <= MaxCnt);
`endif

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Directed self-checking bench for ram_arbiter (2 hosts, depth 2)
//            with a fixed-latency RAM model driving the device response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

   localparam int NH = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MO = 2;
   localparam int CW = $clog2(MO + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                       rst;
   logic [NH-1:0]              host_req;
   logic [NH-1:0]              host_gnt;
   logic [NH-1:0][AW-1:0]      host_addr;
   logic [NH-1:0]              host_we;
   logic [NH-1:0][DW/8-1:0]    host_be;
   logic [NH-1:0][DW-1:0]      host_wdata;
   logic [NH-1:0]              host_rvalid;
   logic [NH-1:0][DW-1:0]      host_rdata;
   logic [NH-1:0]              host_err;
   logic                       dev_req;
   logic [AW-1:0]              dev_addr;
   logic                       dev_we;
   logic [DW/8-1:0]            dev_be;
   logic [DW-1:0]              dev_wdata;
   logic                       dev_rvalid;
   logic [DW-1:0]              dev_rdata;
   logic                       dev_err;
   logic [CW-1:0]              outstanding;
   logic                       orphan;

   int n_checks = 0;
   int n_pass   = 0;

   // RAM model: response pipeline, stage 0 is presented to the DUT.
   logic          pv [8] = '{default: 1'b0};
   logic [DW-1:0] pd [8] = '{default: '0};
   logic          pe [8] = '{default: 1'b0};
   int            lat = 1;
   logic          inj = 1'b0;
   logic          s_req, s_we;
   logic [AW-1:0] s_addr;

   assign dev_rvalid = pv[0] | inj;
   assign dev_rdata  = pd[0];
   assign dev_err    = pv[0] & pe[0];

   function automatic logic [DW-1:0] ram_data(input logic [AW-1:0] a);
      return (a == 32'h0020_0010) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         s_req  = dev_req;
         s_we   = dev_we;
         s_addr = dev_addr;
         #1;
         for (int i = 0; i < 7; i++) begin
            pv[i] = pv[i+1];
            pd[i] = pd[i+1];
            pe[i] = pe[i+1];
         end
         pv[7] = 1'b0;
         pd[7] = '0;
         pe[7] = 1'b0;
         if (s_req) begin
            pv[lat-1] = 1'b1;
            pd[lat-1] = s_we ? '0 : ram_data(s_addr);
            pe[lat-1] = (s_addr == 32'h0000_0BAD);
         end
      end
   end

   ram_arbiter #(
      .NrHosts        (NH),
      .DataWidth      (DW),
      .AddressWidth   (AW),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .host_req_i      (host_req),
      .host_gnt_o      (host_gnt),
      .host_addr_i     (host_addr),
      .host_we_i       (host_we),
      .host_be_i       (host_be),
      .host_wdata_i    (host_wdata),
      .host_rvalid_o   (host_rvalid),
      .host_rdata_o    (host_rdata),
      .host_err_o      (host_err),
      .device_req_o    (dev_req),
      .device_addr_o   (dev_addr),
      .device_we_o     (dev_we),
      .device_be_o     (dev_be),
      .device_wdata_o  (dev_wdata),
      .device_rvalid_i (dev_rvalid),
      .device_rdata_i  (dev_rdata),
      .device_err_i    (dev_err),
      .outstanding_o   (outstanding),
      .orphan_rsp_o    (orphan)
   );

   task automatic idle(input int n);
      host_req = '0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; host_req = 2'b11;
      host_addr[0] = 32'h100; host_addr[1] = 32'h204;
      host_we = '0; host_be = '1; host_wdata = '0;
      @(negedge clk); #1;
      n_checks++; if (host_gnt !== 2'b00) $display("FAIL rst_gnt: got %b want 00", host_gnt); else n_pass++;
      n_checks++; if (dev_req !== 1'b0) $display("FAIL rst_dev_req: got %b want 0", dev_req); else n_pass++;
      n_checks++; if (dev_addr !== '0) $display("FAIL rst_dev_addr: got %h want 0", dev_addr); else n_pass++;
      n_checks++; if (host_rvalid !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", host_rvalid); else n_pass++;
      n_checks++; if (host_err !== 2'b00) $display("FAIL rst_err: got %b want 00", host_err); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (outstanding !== '0) $display("FAIL rst_outstanding: got %0d want 0", outstanding); else n_pass++;
      n_checks++; if (orphan !== 1'b0) $display("FAIL rst_orphan: got %b want 0", orphan); else n_pass++;
      host_req = '0; rst = 1'b0;
      idle(2);
   endtask

   task automatic test_fairness();
      int cnt0 = 0;
      int cnt1 = 0;
      logic [1:0] eg, er;
      lat = 1;
      host_addr[0] = 32'h100; host_addr[1] = 32'h204; host_we = '0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         host_req = (c < 8) ? 2'b11 : 2'b00;
         #1;
         eg = (c >= 8) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
         er = (c == 0) ? 2'b00 : (((c - 1) % 2 == 0) ? 2'b01 : 2'b10);
         n_checks++; if (host_gnt !== eg) $display("FAIL fair_gnt c%0d: got %b want %b", c, host_gnt, eg); else n_pass++;
         if (c < 8) begin
            n_checks++;
            if (dev_addr !== ((c % 2 == 0) ? 32'h100 : 32'h204))
               $display("FAIL fair_addr c%0d: got %h", c, dev_addr);
            else n_pass++;
         end
         n_checks++; if (host_rvalid !== er) $display("FAIL fair_rvalid c%0d: got %b want %b", c, host_rvalid, er); else n_pass++;
         if (host_rvalid[0]) begin
            cnt0++;
            n_checks++; if (host_rdata[0] !== 32'h5A5A_0100) $display("FAIL fair_rdata0: got %h want 5a5a0100", host_rdata[0]); else n_pass++;
         end
         if (host_rvalid[1]) begin
            cnt1++;
            n_checks++; if (host_rdata[1] !== 32'h5A5A_0204) $display("FAIL fair_rdata1: got %h want 5a5a0204", host_rdata[1]); else n_pass++;
         end
      end
      n_checks++; if (cnt0 != 4) $display("FAIL fair_cnt0: got %0d want 4", cnt0); else n_pass++;
      n_checks++; if (cnt1 != 4) $display("FAIL fair_cnt1: got %0d want 4", cnt1); else n_pass++;
      idle(4);
   endtask

   task automatic test_full_stall();
      logic [5:0] eg = 6'b011011;
      int         eo [6] = '{0, 1, 2, 2, 2, 2};
      lat = 3;
      host_addr[0] = 32'h100;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         host_req = 2'b01;
         #1;
         n_checks++; if (host_gnt[0] !== eg[c]) $display("FAIL stall_gnt c%0d: got %b want %b", c, host_gnt[0], eg[c]); else n_pass++;
         n_checks++; if (int'(outstanding) != eo[c]) $display("FAIL stall_outstanding c%0d: got %0d want %0d", c, outstanding, eo[c]); else n_pass++;
         if (c == 3) begin
            n_checks++; if (host_rvalid !== 2'b01) $display("FAIL stall_rvalid c3: got %b want 01", host_rvalid); else n_pass++;
         end
      end
      idle(6);
      #1;
      n_checks++; if (outstanding !== '0) $display("FAIL stall_drain: got %0d want 0", outstanding); else n_pass++;
   endtask

   task automatic test_routing();
      lat = 2;
      @(negedge clk);
      host_req = 2'b10; host_addr[1] = 32'h0020_0010; host_we[1] = 1'b0;
      #1;
      n_checks++; if (host_gnt !== 2'b10) $display("FAIL route_gnt1: got %b want 10", host_gnt); else n_pass++;
      n_checks++; if (dev_addr !== 32'h0020_0010) $display("FAIL route_addr1: got %h want 00200010", dev_addr); else n_pass++;
      n_checks++; if (dev_we !== 1'b0) $display("FAIL route_we1: got %b want 0", dev_we); else n_pass++;
      @(negedge clk);
      host_req = 2'b01; host_addr[0] = 32'h40; host_we[0] = 1'b1;
      host_wdata[0] = 32'h1234_5678; host_be[0] = 4'h3;
      #1;
      n_checks++; if (host_gnt !== 2'b01) $display("FAIL route_gnt0: got %b want 01", host_gnt); else n_pass++;
      n_checks++; if (dev_we !== 1'b1) $display("FAIL route_we0: got %b want 1", dev_we); else n_pass++;
      n_checks++; if (dev_wdata !== 32'h1234_5678) $display("FAIL route_wdata: got %h want 12345678", dev_wdata); else n_pass++;
      n_checks++; if (dev_be !== 4'h3) $display("FAIL route_be: got %h want 3", dev_be); else n_pass++;
      @(negedge clk);
      host_req = '0; host_we = '0; host_be = '1;
      #1;
      n_checks++; if (host_rvalid !== 2'b10) $display("FAIL route_rvalid1: got %b want 10", host_rvalid); else n_pass++;
      n_checks++; if (host_rdata[1] !== 32'hDEAD_BEEF) $display("FAIL route_rdata1: got %h want deadbeef", host_rdata[1]); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (host_rvalid !== 2'b01) $display("FAIL route_rvalid0: got %b want 01", host_rvalid); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (host_rvalid !== 2'b00) $display("FAIL route_rvalid_idle: got %b want 00", host_rvalid); else n_pass++;
      idle(3);
   endtask

   task automatic test_error();
      lat = 1;
      @(negedge clk);
      host_req = 2'b10; host_addr[1] = 32'h0000_0BAD;
      #1;
      n_checks++; if (host_gnt !== 2'b10) $display("FAIL err_gnt1: got %b want 10", host_gnt); else n_pass++;
      n_checks++; if (host_err !== 2'b00) $display("FAIL err_pre: got %b want 00", host_err); else n_pass++;
      @(negedge clk);
      host_req = 2'b01; host_addr[0] = 32'h100;
      #1;
      n_checks++; if (host_rvalid !== 2'b10) $display("FAIL err_rvalid1: got %b want 10", host_rvalid); else n_pass++;
      n_checks++; if (host_err !== 2'b10) $display("FAIL err_route1: got %b want 10", host_err); else n_pass++;
      @(negedge clk);
      host_req = '0;
      #1;
      n_checks++; if (host_rvalid !== 2'b01) $display("FAIL err_rvalid0: got %b want 01", host_rvalid); else n_pass++;
      n_checks++; if (host_err !== 2'b00) $display("FAIL err_route0: got %b want 00", host_err); else n_pass++;
      idle(3);
   endtask

   task automatic test_orphan();
      @(negedge clk);
      inj = 1'b1;
      #1;
      n_checks++; if (orphan !== 1'b1) $display("FAIL orphan_pulse: got %b want 1", orphan); else n_pass++;
      n_checks++; if (host_rvalid !== 2'b00) $display("FAIL orphan_rvalid: got %b want 00", host_rvalid); else n_pass++;
      n_checks++; if (outstanding !== '0) $display("FAIL orphan_out0: got %0d want 0", outstanding); else n_pass++;
      @(negedge clk);
      inj = 1'b0;
      #1;
      n_checks++; if (orphan !== 1'b0) $display("FAIL orphan_end: got %b want 0", orphan); else n_pass++;
      n_checks++; if (outstanding !== '0) $display("FAIL orphan_out1: got %0d want 0", outstanding); else n_pass++;
      idle(2);
   endtask

   task automatic test_reset_midflight();
      lat = 3;
      host_addr[0] = 32'h100; host_addr[1] = 32'h204;
      @(negedge clk); host_req = 2'b01; #1;
      n_checks++; if (host_gnt !== 2'b01) $display("FAIL mid_gnt_a: got %b want 01", host_gnt); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (host_gnt !== 2'b01) $display("FAIL mid_gnt_b: got %b want 01", host_gnt); else n_pass++;
      @(negedge clk); host_req = '0; rst = 1'b1; #1;
      n_checks++; if (outstanding !== 2) $display("FAIL mid_out_pre: got %0d want 2", outstanding); else n_pass++;
      n_checks++; if (dev_req !== 1'b0) $display("FAIL mid_req_rst: got %b want 0", dev_req); else n_pass++;
      @(negedge clk); rst = 1'b0; #1;
      n_checks++; if (outstanding !== '0) $display("FAIL mid_out_post: got %0d want 0", outstanding); else n_pass++;
      n_checks++; if (orphan !== 1'b1) $display("FAIL mid_orphan1: got %b want 1", orphan); else n_pass++;
      n_checks++; if (host_rvalid !== 2'b00) $display("FAIL mid_rvalid: got %b want 00", host_rvalid); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (orphan !== 1'b1) $display("FAIL mid_orphan2: got %b want 1", orphan); else n_pass++;
      @(negedge clk); host_req = 2'b11; #1;
      n_checks++; if (orphan !== 1'b0) $display("FAIL mid_orphan_end: got %b want 0", orphan); else n_pass++;
      n_checks++; if (host_gnt !== 2'b01) $display("FAIL mid_ptr_restart: got %b want 01", host_gnt); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (host_gnt !== 2'b10) $display("FAIL mid_ptr_next: got %b want 10", host_gnt); else n_pass++;
      idle(6);
      #1;
      n_checks++; if (outstanding !== '0) $display("FAIL mid_drain: got %0d want 0", outstanding); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; host_req = '0; host_addr = '0; host_we = '0;
      host_be = '1; host_wdata = '0;
      test_reset();
      test_fairness();
      test_full_stall();
      test_routing();
      test_error();
      test_orphan();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not complete, %0d/%0d passed so far", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_ram_arbiter
`default_nettype wire
